// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: lights one of nine cells per round and scores keypad hits.
// Optional build macro MOLE_SPEEDUP_EN shortens the show window after every correct hit.
module mole_game_ctrl #(
    parameter int TICK_DIV       = 50000,
    parameter int SHOW_TICKS     = 800,
    parameter int MIN_SHOW_TICKS = 200,
    parameter int HIT_TICKS      = 300,
    parameter int GAP_TICKS      = 200,
    parameter int ROUNDS         = 30,
    parameter int MAX_MISS       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       inGame,
    output logic [3:0] position,
    output logic       hit,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        SHOW,
        FEEDBACK,
        GAP,
        DONE
    } state_t;

    localparam logic [31:0] PRE_MAX  = 32'(TICK_DIV - 1);
    localparam logic [15:0] SHOW_L   = 16'(SHOW_TICKS);
    localparam logic [15:0] HIT_L    = 16'(HIT_TICKS);
    localparam logic [15:0] GAP_L    = 16'(GAP_TICKS);
    localparam logic [15:0] MIN_L    = 16'(MIN_SHOW_TICKS);
    localparam logic [7:0]  ROUNDS_L = 8'(ROUNDS);
    localparam logic [3:0]  MAX_L    = 4'(MAX_MISS);

    state_t      state, state_n;
    logic [31:0] pre, pre_n;
    logic [15:0] timer, timer_n;
    logic [15:0] reload, reload_n, reload_dec;
    logic [7:0]  lfsr;
    logic [7:0]  rounds, rounds_n;
    logic [7:0]  score_n;
    logic [3:0]  misses_n, position_n;
    logic [3:0]  last, last_n, cand;
    logic [4:0]  miss_sum;
    logic        hit_n, tick, expire, cand_ok, fb;

    assign tick    = (pre == PRE_MAX);
    assign expire  = tick && (timer == 16'd1);
    assign cand    = lfsr[3:0];
    assign cand_ok = (cand >= 4'd1) && (cand <= 4'd9) && (cand != last);
    assign fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

`ifdef MOLE_SPEEDUP_EN
    localparam logic [15:0] STEP_L = 16'(SHOW_TICKS / 16);

    // next show reload after a hit: shrink by one step, never below the floor
    always_comb begin
        reload_dec = MIN_L;
        if (reload >= MIN_L + STEP_L) reload_dec = reload - STEP_L;
    end
`else
    logic unused_min;
    assign unused_min = ^MIN_L;
    assign reload_dec = SHOW_L;
`endif

    // next-state, timers, counters and next output values
    always_comb begin
        state_n    = state;
        pre_n      = tick ? 32'd0 : pre + 32'd1;
        timer_n    = timer;
        reload_n   = reload;
        rounds_n   = rounds;
        score_n    = score;
        misses_n   = misses;
        position_n = position;
        hit_n      = hit;
        last_n     = last;
        miss_sum   = {1'b0, misses};
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    score_n    = 8'd0;
                    misses_n   = 4'd0;
                    rounds_n   = 8'd0;
                    pre_n      = 32'd0;
                    reload_n   = SHOW_L;
                    position_n = 4'd0;
                    hit_n      = 1'b0;
                    state_n    = SPAWN;
                end
            end
            SPAWN: begin
                position_n = 4'd0;
                hit_n      = 1'b0;
                if (cand_ok) begin
                    position_n = cand;
                    last_n     = cand;
                    timer_n    = reload;
                    pre_n      = 32'd0;
                    state_n    = SHOW;
                end
            end
            SHOW: begin
                if (key_valid && key_code == position) begin
                    hit_n    = 1'b1;
                    score_n  = (score == 8'hFF) ? score : score + 8'd1;
                    timer_n  = HIT_L;
                    pre_n    = 32'd0;
                    reload_n = reload_dec;
                    state_n  = FEEDBACK;
                end else begin
                    miss_sum = {1'b0, misses} + {4'd0, key_valid}
                             + {4'd0, expire};
                    misses_n = (miss_sum > 5'd15) ? 4'hF : miss_sum[3:0];
                    if (tick) timer_n = timer - 16'd1;
                    if (expire || misses_n >= MAX_L) begin
                        position_n = 4'd0;
                        timer_n    = GAP_L;
                        pre_n      = 32'd0;
                        state_n    = GAP;
                    end
                end
            end
            FEEDBACK: begin
                if (expire) begin
                    position_n = 4'd0;
                    hit_n      = 1'b0;
                    timer_n    = GAP_L;
                    pre_n      = 32'd0;
                    state_n    = GAP;
                end else if (tick) begin
                    timer_n = timer - 16'd1;
                end
            end
            GAP: begin
                position_n = 4'd0;
                hit_n      = 1'b0;
                if (expire) begin
                    rounds_n = rounds + 8'd1;
                    if (rounds_n == ROUNDS_L || misses >= MAX_L)
                        state_n = DONE;
                    else
                        state_n = SPAWN;
                end else if (tick) begin
                    timer_n = timer - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state, counters, LFSR and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pre       <= 32'd0;
            timer     <= 16'd0;
            reload    <= SHOW_L;
            lfsr      <= 8'hA5;
            rounds    <= 8'd0;
            last      <= 4'd0;
            inGame    <= 1'b0;
            position  <= 4'd0;
            hit       <= 1'b0;
            score     <= 8'd0;
            misses    <= 4'd0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            pre       <= pre_n;
            timer     <= timer_n;
            reload    <= reload_n;
            lfsr      <= {lfsr[6:0], fb};
            rounds    <= rounds_n;
            last      <= last_n;
            inGame    <= (state_n != IDLE) && (state_n != DONE);
            position  <= position_n;
            hit       <= hit_n;
            score     <= score_n;
            misses    <= misses_n;
            game_over <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl: step table plus timing corner sequences.
// Define MOLE_SPEEDUP_EN to exercise the show-window speed-up build instead.
module tb_mole_game_ctrl;

    localparam int TD  = 4;
    localparam int MNS = 4;
    localparam int HT  = 2;
    localparam int GT  = 2;
    localparam int MM  = 2;
`ifdef MOLE_SPEEDUP_EN
    localparam int SHOW = 16;
    localparam int RND  = 6;
`else
    localparam int SHOW = 8;
    localparam int RND  = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       in_game;
    logic [3:0] position;
    logic       hit;
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mole_game_ctrl #(
        .TICK_DIV      (TD),
        .SHOW_TICKS    (SHOW),
        .MIN_SHOW_TICKS(MNS),
        .HIT_TICKS     (HT),
        .GAP_TICKS     (GT),
        .ROUNDS        (RND),
        .MAX_MISS      (MM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_valid(key_valid),
        .key_code (key_code),
        .inGame   (in_game),
        .position (position),
        .hit      (hit),
        .score    (score),
        .misses   (misses),
        .game_over(game_over)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        cyc();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic wait_show();
        int n = 0;
        while (!(position != 4'd0 && !hit) && n < 200) begin
            cyc();
            n++;
        end
        chk("wait_show_bound", int'(n < 200), 1);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!game_over && n < 200) begin
            cyc();
            n++;
        end
        chk("wait_end_bound", int'(n < 200), 1);
    endtask

    // cycles from now until misses changes
    task automatic time_to_miss(output int n);
        logic [3:0] m0;
        m0 = misses;
        n  = 0;
        while (misses == m0 && n < 200) begin
            cyc();
            n++;
        end
    endtask

    function automatic logic [3:0] wrong_key(input logic [3:0] p);
        return (p == 4'd9) ? 4'd1 : p + 4'd1;
    endfunction

    typedef enum int {OP_RST, OP_START, OP_SHOW, OP_HIT, OP_WRONG, OP_END} op_t;

    typedef struct {
        op_t op;
        int  score;
        int  misses;
        int  hit;
        int  ing;
        int  go;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
`ifdef MOLE_SPEEDUP_EN
        do_reset();
        chk("rst_score", int'(score), 0);
        chk("rst_ingame", int'(in_game), 0);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            wait_show();
            repeat ((SHOW - i) * TD - 1) cyc();
            chk($sformatf("win%0d_open_misses", i), int'(misses), 0);
            chk($sformatf("win%0d_open_pos", i), int'(position != 4'd0), 1);
            press(position);
            chk($sformatf("win%0d_hit", i), int'(hit), 1);
            chk($sformatf("win%0d_score", i), int'(score), i + 1);
        end
        wait_show();
        time_to_miss(n);
        chk("win5_timeout_clk", n, (SHOW - 5) * TD);
        wait_end();
        chk("sp_game_over", int'(game_over), 1);
        chk("sp_score_held", int'(score), 5);
        pulse_start();
        chk("sp_restart_score", int'(score), 0);
        wait_show();
        time_to_miss(n);
        chk("restore_timeout_clk", n, SHOW * TD);
`else
        vec_t tbl[17];
        tbl[0]  = '{OP_RST,   0, 0, 0, 0, 0};
        tbl[1]  = '{OP_START, 0, 0, 0, 1, 0};
        tbl[2]  = '{OP_SHOW,  0, 0, 0, 1, 0};
        tbl[3]  = '{OP_HIT,   1, 0, 1, 1, 0};
        tbl[4]  = '{OP_START, 1, 0, 1, 1, 0};
        tbl[5]  = '{OP_SHOW,  1, 0, 0, 1, 0};
        tbl[6]  = '{OP_HIT,   2, 0, 1, 1, 0};
        tbl[7]  = '{OP_SHOW,  2, 0, 0, 1, 0};
        tbl[8]  = '{OP_HIT,   3, 0, 1, 1, 0};
        tbl[9]  = '{OP_END,   3, 0, 0, 0, 1};
        tbl[10] = '{OP_START, 0, 0, 0, 1, 0};
        tbl[11] = '{OP_SHOW,  0, 0, 0, 1, 0};
        tbl[12] = '{OP_HIT,   1, 0, 1, 1, 0};
        tbl[13] = '{OP_SHOW,  1, 0, 0, 1, 0};
        tbl[14] = '{OP_WRONG, 1, 1, 0, 1, 0};
        tbl[15] = '{OP_END,   1, 2, 0, 0, 1};
        tbl[16] = '{OP_START, 0, 0, 0, 1, 0};

        for (int i = 0; i < 17; i++) begin
            unique case (tbl[i].op)
                OP_RST:   do_reset();
                OP_START: pulse_start();
                OP_SHOW:  wait_show();
                OP_HIT:   press(position);
                OP_WRONG: press(wrong_key(position));
                OP_END:   wait_end();
                default:  cyc();
            endcase
            chk($sformatf("row%0d_score", i), int'(score), tbl[i].score);
            chk($sformatf("row%0d_misses", i), int'(misses), tbl[i].misses);
            chk($sformatf("row%0d_hit", i), int'(hit), tbl[i].hit);
            chk($sformatf("row%0d_ingame", i), int'(in_game), tbl[i].ing);
            chk($sformatf("row%0d_gameover", i), int'(game_over), tbl[i].go);
        end

        // timeout window and hit hold timing
        do_reset();
        pulse_start();
        wait_show();
        time_to_miss(n);
        chk("timeout_clk", n, SHOW * TD);
        chk("timeout_misses", int'(misses), 1);
        chk("gap_position", int'(position), 0);
        chk("gap_ingame", int'(in_game), 1);
        wait_show();
        press(position);
        chk("hit_set", int'(hit), 1);
        chk("hit_score", int'(score), 1);
        n = 0;
        while (hit && n < 100) begin
            cyc();
            n++;
        end
        chk("hit_hold_clk", n, HT * TD);
        chk("after_hit_position", int'(position), 0);

        // correct key on the expiring tick wins over the timeout
        wait_show();
        repeat (SHOW * TD - 1) cyc();
        press(position);
        chk("collide_score", int'(score), 2);
        chk("collide_misses", int'(misses), 1);
        chk("collide_hit", int'(hit), 1);

        // reset in FEEDBACK clears everything
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_ingame", int'(in_game), 0);
        chk("midrst_position", int'(position), 0);
        chk("midrst_hit", int'(hit), 0);
        chk("midrst_score", int'(score), 0);
        chk("midrst_misses", int'(misses), 0);
        chk("midrst_gameover", int'(game_over), 0);

        // reset beats a simultaneous start
        start = 1'b1;
        rst   = 1'b1;
        cyc();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_vs_start_ingame", int'(in_game), 0);
        repeat (5) cyc();
        chk("idle_ingame", int'(in_game), 0);
        chk("idle_gameover", int'(game_over), 0);
        chk("idle_position", int'(position), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mole_game_ctrl.md
MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, giving clk cycles per game tick (1 kHz at 50 MHz).
REQ-002 The block SHALL have parameter SHOW_TICKS, default 800, giving ticks a target stays lit.
REQ-003 The block SHALL have parameter MIN_SHOW_TICKS, default 200, giving the speed-up floor (see Configuration).
REQ-004 The block SHALL have parameter HIT_TICKS, default 300, giving ticks the hit feedback is held.
REQ-005 The block SHALL have parameter GAP_TICKS, default 200, giving blank ticks between rounds.
REQ-006 The block SHALL have parameter ROUNDS, default 30, giving rounds per game.
REQ-007 The block SHALL have parameter MAX_MISS, default 10, giving the miss count that ends the game early.
REQ-008 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named `clk` and `rst`:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse that begins a game
- key_valid  in  1  one-cycle strobe marking a keypad press
- key_code  in  4  cell pressed, 1..9; qualified by key_valid
- inGame  out  1  game running; feeds the display
- position  out  4  lit cell, 1..9, or 0 for none; feeds the display
- hit  out  1  current target was hit; feeds the display
- score  out  8  number of hits
- misses  out  4  number of misses
- game_over  out  1  game finished

Function
REQ-009 The block SHALL contain a prescaler counting 0..TICK_DIV-1 that emits a one-cycle tick on wrap; the counter SHALL clear on start acceptance.
REQ-010 The state machine SHALL have the states IDLE, SPAWN, SHOW, FEEDBACK, GAP and DONE.
REQ-011 The block SHALL contain an 8-bit LFSR with polynomial x^8+x^6+x^5+x^4+1 and seed 8'hA5 that advances every clk cycle in every state.
REQ-012 In IDLE or DONE, a start pulse SHALL clear score, misses and the round counter, then move to SPAWN; start SHALL be ignored in every other state.
REQ-013 In SPAWN, the block SHALL accept when lfsr[3:0] is in 1..9 and differs from the previous target.
- On acceptance it SHALL load position and the show timer, then move to SHOW.
- Otherwise it SHALL stay in SPAWN and retry on the next cycle.
- position SHALL be 0 while in SPAWN.
REQ-014 In SHOW, the show timer SHALL decrement once per tick.
- key_valid with key_code==position SHALL set hit=1, increment score, load HIT_TICKS and move to FEEDBACK.
REQ-015 In SHOW, key_valid with any other key_code SHALL increment misses and stay in SHOW.
REQ-016 In SHOW, a tick arriving while the timer is 1 SHALL increment misses and move to GAP.
- If a correct key arrives in the same cycle, the correct key SHALL win and the timeout miss SHALL NOT be counted.
REQ-017 In FEEDBACK, position and hit=1 SHALL be held for HIT_TICKS ticks, then the block SHALL move to GAP.
- key_valid SHALL be ignored in FEEDBACK.
REQ-018 In GAP, position SHALL be 0 and hit SHALL be 0 for GAP_TICKS ticks.
- At expiry the round counter SHALL increment.
- If rounds==ROUNDS or misses>=MAX_MISS the block SHALL move to DONE, otherwise to SPAWN.
- key_valid SHALL be ignored in GAP.
REQ-019 The block SHALL end the game as soon as misses reaches MAX_MISS in SHOW, moving to GAP and then DONE without waiting for the remaining rounds.
REQ-020 inGame SHALL be 1 exactly in SPAWN, SHOW, FEEDBACK and GAP.
REQ-021 game_over SHALL be 1 only in DONE; in DONE, score and misses SHALL hold.
REQ-022 score SHALL saturate at 255 and misses SHALL saturate at 15.
REQ-023 All outputs SHALL be registered, and state changes SHALL be visible one cycle after the causing input.

Reset
REQ-024 rst high at any clk edge, including mid-game, SHALL force IDLE.
- Outputs SHALL reset to inGame=0, position=0, hit=0, score=0, misses=0, game_over=0.
- Prescaler and timers SHALL reset to 0 and the LFSR SHALL reset to 8'hA5.
REQ-025 rst SHALL take priority over start and key_valid in the same cycle.

Configuration
REQ-026 The macro MOLE_SPEEDUP_EN SHALL control show-window speed-up.
- When defined, each correct hit SHALL reduce the show reload by SHOW_TICKS/16, floored at MIN_SHOW_TICKS.
- When defined, the show reload SHALL restore to SHOW_TICKS on start.
- When undefined, the show reload SHALL always be SHOW_TICKS and MIN_SHOW_TICKS SHALL be unused.

Verification
Benches SHALL use TICK_DIV=4, SHOW_TICKS=8, MIN_SHOW_TICKS=4, HIT_TICKS=2, GAP_TICKS=2, ROUNDS=3, MAX_MISS=2, unless a scenario states otherwise.
REQ-027 Correct hit: start, then key_valid with key_code=position in SHOW -> next cycle hit=1 and score=1, hit held 8 clk, then position=0 in GAP.
REQ-028 Timeout: no key through SHOW -> misses=1 exactly 32 clk after position is loaded, then GAP.
REQ-029 Early end: a wrong key, then a timeout -> misses=2, then DONE after GAP with game_over=1, inGame=0 and score held.
REQ-030 Full game: 3 correct hits -> DONE with score=3 and misses=0; second start -> score=0, inGame=1.
REQ-031 Collision and reset: correct key on the expiring tick -> score+1 and misses unchanged; rst asserted in FEEDBACK -> next cycle all outputs 0 and state IDLE.
REQ-032 Speed-up, with MOLE_SPEEDUP_EN defined and SHOW_TICKS=16: 5 hits -> show windows of 16, 15, 14, 13, 12 ticks, and a later start restores 16.
